// File: rtl/imager_cfg_seq_pkg.sv
// Shared types for the imager power-up / register-configuration sequencer.
package imager_cfg_pkg;

  localparam int FRAME_W = 24;
  localparam int RW_BIT  = 23;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_LOW,
    S_CLR_WAIT,
    S_FETCH,
    S_SHIFT,
    S_GAP,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_e;

  typedef struct packed {
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  data;
  } tbl_entry_t;

endpackage

// File: rtl/imager_cfg_seq_spi.sv
// One 24-bit SPI mode-0 frame: XCE low, 24 SCLK periods of 2*CLK_DIV cycles, XCE high after a tail.
module spi_frame_shifter
  import imager_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               go_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               miso_i,
  output logic               xce_o,
  output logic               sclk_o,
  output logic               mosi_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] rx_o
);

  // 48 SCLK toggles plus the XCE-release event
  localparam logic [5:0]  LAST_EV = 6'(2 * FRAME_W + 1);
  localparam logic [15:0] DIV_TOP = 16'(CLK_DIV - 1);

  logic               active_q;
  logic [15:0]        div_q;
  logic [5:0]         ev_q;
  logic [FRAME_W-1:0] tx_q;
  logic [FRAME_W-1:0] rx_q;
  logic               xce_q;
  logic               sclk_q;
  logic               mosi_q;
  logic               tick;
  logic [5:0]         ev_nx;

  assign tick   = active_q && (div_q == 16'd0);
  assign ev_nx  = ev_q + 6'd1;
  assign done_o = tick && (ev_nx == LAST_EV);
  assign xce_o  = xce_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      ev_q     <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      xce_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else if (go_i && !active_q) begin
      active_q <= 1'b1;
      div_q    <= DIV_TOP;
      ev_q     <= '0;
      tx_q     <= frame_i;
      rx_q     <= '0;
      xce_q    <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= frame_i[RW_BIT];
    end else if (tick) begin
      div_q <= DIV_TOP;
      ev_q  <= ev_nx;
      if (ev_nx == LAST_EV) begin
        active_q <= 1'b0;
        xce_q    <= 1'b1;
        mosi_q   <= 1'b0;
      end else if (ev_nx[0]) begin
        sclk_q <= 1'b1;
        rx_q   <= {rx_q[FRAME_W-2:0], miso_i};
      end else begin
        sclk_q <= 1'b0;
        tx_q   <= {tx_q[FRAME_W-2:0], 1'b0};
        mosi_q <= tx_q[FRAME_W-2];
      end
    end else if (active_q) begin
      div_q <= div_q - 16'd1;
    end
  end

endmodule

// File: rtl/imager_cfg_seq.sv
// Sensor power-up sequencer: XCLR pulse, then the register table over SPI.
// Optional readback check is built when IMG_CFG_VERIFY_EN is defined.
module imager_cfg_seq
  import imager_cfg_pkg::*;
#(
  parameter int          CLK_DIV       = 4,
  parameter int          XCLR_LOW_CYC  = 1000,
  parameter int          XCLR_WAIT_CYC = 2000,
  parameter int          NUM_REGS      = 16,
  parameter logic [14:0] VERIFY_ADDR   = 15'h0000,
  parameter logic [7:0]  VERIFY_VAL    = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic        XCLR,
  output logic        XCE,
  output logic        SCLK,
  output logic        X_MOSI,
  input  logic        X_MISO,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data
);

  localparam logic [8:0] LAST_IDX = 9'(NUM_REGS - 1);

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         addr_q, addr_d;
  logic               xclr_q, xclr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         rd_q, rd_d;
  logic               sh_go, sh_done, sh_miso;
  logic [FRAME_W-1:0] sh_frame, sh_rx;
  logic               unused_bits;

`ifdef IMG_CFG_VERIFY_EN
  tbl_entry_t vfy_entry;
  assign vfy_entry   = '{rw: 1'b1, addr: VERIFY_ADDR, data: 8'h00};
  assign sh_miso     = X_MISO;
  assign unused_bits = ^sh_rx[FRAME_W-1:8];
`else
  assign sh_miso     = 1'b0;
  assign unused_bits = ^{X_MISO, sh_rx, VERIFY_ADDR, VERIFY_VAL};
`endif

  spi_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .go_i    (sh_go),
    .frame_i (sh_frame),
    .miso_i  (sh_miso),
    .xce_o   (XCE),
    .sclk_o  (SCLK),
    .mosi_o  (X_MOSI),
    .done_o  (sh_done),
    .rx_o    (sh_rx)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      xclr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      xclr_q  <= xclr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    xclr_d   = xclr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    rd_d     = rd_q;
    sh_go    = 1'b0;
    sh_frame = tbl_data;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_CLR_LOW;
          cnt_d   = 16'(XCLR_LOW_CYC - 1);
          addr_d  = '0;
          xclr_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CLR_LOW: begin
        if (cnt_q == 16'd0) begin
          state_d = S_CLR_WAIT;
          cnt_d   = 16'(XCLR_WAIT_CYC - 1);
          xclr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CLR_WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = S_FETCH;
          cnt_d   = 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      // ROM output is valid on the second FETCH cycle
      S_FETCH: begin
        if (cnt_q == 16'd0) begin
          sh_go   = 1'b1;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SHIFT: begin
        if (sh_done) begin
          state_d = S_GAP;
          cnt_d   = 16'(2 * CLK_DIV - 1);
        end
      end
      S_GAP: begin
        if (cnt_q == 16'd0) begin
          if ({1'b0, addr_q} < LAST_IDX) begin
            addr_d  = addr_q + 8'd1;
            state_d = S_FETCH;
            cnt_d   = 16'd1;
          end else begin
`ifdef IMG_CFG_VERIFY_EN
            sh_go    = 1'b1;
            sh_frame = vfy_entry;
            state_d  = S_VERIFY;
`else
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef IMG_CFG_VERIFY_EN
      S_VERIFY: begin
        if (sh_done) begin
          rd_d   = sh_rx[7:0];
          busy_d = 1'b0;
          if (sh_rx[7:0] == VERIFY_VAL) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign tbl_addr = addr_q;
  assign XCLR     = xclr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = err_q;
  assign rd_data  = rd_q;

endmodule

// File: tb/tb_imager_cfg_seq.sv
// Bench for imager_cfg_seq: ROM + SPI sensor model, randomized tables and readback bytes.
module tb_imager_cfg_seq;

  localparam int          CD    = 2;
  localparam int          LOW   = 10;
  localparam int          WAIT  = 20;
  localparam int          NREG  = 3;
  localparam logic [14:0] VADDR = 15'h3000;
  localparam logic [7:0]  VVAL  = 8'h5A;
  localparam int          LIMIT = 3000;
`ifdef IMG_CFG_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        XCLR, XCE, SCLK, X_MOSI;
  logic        miso_tb = 1'b0;
  logic        busy, done, error;
  logic [7:0]  rd_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [23:0] rom [0:255];
  logic [23:0] resp = '0;
  logic [23:0] exp_f [0:NREG];

  imager_cfg_seq #(
    .CLK_DIV(CD), .XCLR_LOW_CYC(LOW), .XCLR_WAIT_CYC(WAIT),
    .NUM_REGS(NREG), .VERIFY_ADDR(VADDR), .VERIFY_VAL(VVAL)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .XCLR(XCLR), .XCE(XCE), .SCLK(SCLK), .X_MOSI(X_MOSI), .X_MISO(miso_tb),
    .busy(busy), .done(done), .error(error), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) tbl_data <= rom[tbl_addr];

  // Sensor-side SPI model and event log, sampled mid-cycle
  int          fall_t[$];
  int          rise_t[$];
  int          xclr_t[$];
  int          nrise_q[$];
  logic [23:0] words[$];
  logic [23:0] cur = '0;
  int          nr = 0;
  int          midx = 0;
  int          tot_rises = 0;
  logic        pxce = 1'b1, psclk = 1'b0, pxclr = 1'b0;

  always @(negedge sys_clk) begin
    if (pxce && !XCE) begin
      fall_t.push_back(cyc);
      cur = '0; nr = 0; midx = 0;
      miso_tb = resp[23];
    end
    if (!pxce && XCE) begin
      rise_t.push_back(cyc);
      words.push_back(cur);
      nrise_q.push_back(nr);
    end
    if (!psclk && SCLK) begin
      tot_rises++;
      if (!XCE) begin
        cur = {cur[22:0], X_MOSI};
        nr++;
      end
    end
    if (psclk && !SCLK && !XCE) begin
      midx++;
      miso_tb = (midx < 24) ? resp[23 - midx] : 1'b0;
    end
    if (!pxclr && XCLR) xclr_t.push_back(cyc);
    pxce = XCE; psclk = SCLK; pxclr = XCLR;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic load_table(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    rom[0] = a; rom[1] = b; rom[2] = c;
    exp_f[0] = a; exp_f[1] = b; exp_f[2] = c;
    exp_f[NREG] = {1'b1, VADDR, 8'h00};
  endtask

  task automatic run_seq(input logic [7:0] rbyte, input bit dbl_start);
    int b, t0, k, nf;
    resp = {16'h0, rbyte};
    b = fall_t.size();
    @(negedge sys_clk); start = 1'b1; t0 = cyc;
    @(negedge sys_clk); start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("done_cleared", {31'b0, done}, 32'd0);
    check("error_cleared", {31'b0, error}, 32'd0);
    check("addr_restart", {24'b0, tbl_addr}, 32'd0);
    check("xclr_low", {31'b0, XCLR}, 32'd0);
    if (dbl_start) begin
      repeat (18) @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk); start = 1'b0;
    end
    k = 0;
    while (!(done || error) && k < LIMIT) begin
      @(negedge sys_clk); k++;
    end
    check("seq_timeout", {31'b0, k < LIMIT}, 32'd1);
    nf = NREG + int'(VFY);
    check("frame_count", fall_t.size() - b, nf);
    check("xclr_rise", xclr_t[$] - t0, LOW + 1);
    if (fall_t.size() > b) check("first_xce_fall", fall_t[b] - t0, LOW + WAIT + 3);
    for (int i = 0; i < nf && b + i < rise_t.size(); i++) begin
      check("frame_word", words[b + i], exp_f[(i < NREG) ? i : NREG]);
      check("sclk_rises", nrise_q[b + i], 24);
      check("frame_len", rise_t[b + i] - fall_t[b + i], 49 * CD);
      if (i > 0 && i < NREG) check("gap_len", fall_t[b + i] - rise_t[b + i - 1], 2 * CD + 2);
      if (i == NREG) check("vfy_gap_min", {31'b0, fall_t[b + i] - rise_t[b + i - 1] >= 2 * CD}, 32'd1);
    end
    check("done_flag", {31'b0, done}, VFY ? {31'b0, rbyte == VVAL} : 32'd1);
    check("error_flag", {31'b0, error}, VFY ? {31'b0, rbyte != VVAL} : 32'd0);
    check("rd_data", {24'b0, rd_data}, VFY ? {24'b0, rbyte} : 32'd0);
    check("busy_end", {31'b0, busy}, 32'd0);
    check("xclr_held", {31'b0, XCLR}, 32'd1);
  endtask

  task automatic reset_mid_shift();
    int b, k, tr;
    resp = '0;
    b = fall_t.size();
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    k = 0;
    while (!(fall_t.size() > b && nr >= 10) && k < LIMIT) begin
      @(negedge sys_clk); k++;
    end
    check("reach_bit10", {31'b0, k < LIMIT}, 32'd1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    tr = tot_rises;
    check("rst_xce", {31'b0, XCE}, 32'd1);
    check("rst_sclk", {31'b0, SCLK}, 32'd0);
    check("rst_xclr", {31'b0, XCLR}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_addr", {24'b0, tbl_addr}, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (60) @(negedge sys_clk);
    check("no_sclk_after_rst", tot_rises, tr);
    check("idle_xce", {31'b0, XCE}, 32'd1);
    check("idle_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_xclr", {31'b0, XCLR}, 32'd0);
    check("reset_xce", {31'b0, XCE}, 32'd1);
    check("reset_sclk", {31'b0, SCLK}, 32'd0);
    check("reset_mosi", {31'b0, X_MOSI}, 32'd0);
    check("reset_addr", {24'b0, tbl_addr}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_error", {31'b0, error}, 32'd0);
    check("reset_rd", {24'b0, rd_data}, 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    load_table(24'h300001, 24'h3001A5, 24'h7FFFFF);
    run_seq(8'h5A, 1'b1);
    run_seq(8'h00, 1'b0);
    run_seq(8'h5A, 1'b0);

    for (int r = 0; r < 4; r++) begin
      load_table({1'b0, 15'($urandom), 8'($urandom)},
                 {1'b0, 15'($urandom), 8'($urandom)},
                 {1'b0, 15'($urandom), 8'($urandom)});
      rb = ($urandom_range(0, 1) == 1) ? VVAL : 8'($urandom);
      run_seq(rb, r[0]);
    end

    reset_mid_shift();
    load_table({1'b0, 15'($urandom), 8'($urandom)}, 24'h0055AA, {1'b0, 15'($urandom), 8'($urandom)});
    run_seq(VVAL, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
